// File: rtl/hemaia_clk_div_cfg_ctrl.sv
// Configuration sequencer for a bank of hemaia_clock_divider instances.
// Serialises divisor updates: issue to one or all dividers, wait a settle window, then respond.
module hemaia_clk_div_cfg_ctrl #(
  parameter int unsigned NumClocks        = 4,
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned SettleCycles     = 36,
  parameter int unsigned ChanWidth        = (NumClocks > 1) ? $clog2(NumClocks) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [ChanWidth-1:0]                  req_chan_i,
  input  logic                                  req_broadcast_i,
  input  logic [MaxDivisionWidth-1:0]           req_divisor_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic                                  rsp_err_o,
  output logic [NumClocks*MaxDivisionWidth-1:0] div_divisor_o,
  output logic [NumClocks-1:0]                  div_valid_o,
  output logic                                  busy_o
);

  localparam int unsigned CntWidth = $clog2(SettleCycles);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StApply  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]                  state_q;
  logic [CntWidth-1:0]         cnt_q;
  logic                        err_q;
  logic [NumClocks-1:0]        valid_q;
  logic [NumClocks-1:0]        req_mask;
  logic                        req_invalid;
  logic [MaxDivisionWidth-1:0] divisor_q [NumClocks];

  // Target decode: broadcast hits every divider and can never be out of range.
  always_comb begin
    req_invalid = !req_broadcast_i && (int'(req_chan_i) >= int'(NumClocks));
    req_mask    = '0;
    for (int k = 0; k < int'(NumClocks); k++) begin
      req_mask[k] = req_broadcast_i || (int'(req_chan_i) == k);
    end
  end

  // Divisors and valid pulses are registered at acceptance so they are visible
  // during the APPLY cycle; the divisor is then held until the next update
  // because each divider only samples it at its own counter wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
      for (int k = 0; k < int'(NumClocks); k++) begin
        divisor_q[k] <= MaxDivisionWidth'(DefaultDivision);
      end
    end else begin
      valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (req_invalid) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              for (int k = 0; k < int'(NumClocks); k++) begin
                if (req_mask[k]) divisor_q[k] <= req_divisor_i;
              end
              valid_q <= req_mask;
              state_q <= StApply;
            end
          end
        end
        StApply: begin
          cnt_q   <= CntWidth'(SettleCycles - 1);
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = (state_q == StResp) && err_q;
  assign div_valid_o = valid_q;

  for (genvar g = 0; g < int'(NumClocks); g++) begin : gen_div_out
    assign div_divisor_o[g*MaxDivisionWidth +: MaxDivisionWidth] = divisor_q[g];
  end

endmodule
